// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the auxiliary unit (port 1).
// Optional statistics counters are compiled in when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int WORDS    = 32,
    parameter int CTRLBITS = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [CTRLBITS-1:0] req0_ctr,
    input  logic [WORDS-1:0]    req0_a,
    input  logic [WORDS-1:0]    req0_b,
    input  logic [WORDS-1:0]    req0_pc,
    input  logic [WORDS-1:0]    req0_imm,
    input  logic                req0_srca,
    input  logic                req0_srcb,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [CTRLBITS-1:0] req1_ctr,
    input  logic [WORDS-1:0]    req1_a,
    input  logic [WORDS-1:0]    req1_b,
    input  logic [WORDS-1:0]    req1_pc,
    input  logic [WORDS-1:0]    req1_imm,
    input  logic                req1_srca,
    input  logic                req1_srcb,

    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WORDS-1:0]    rsp0_result,
    output logic                rsp0_zero,

    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WORDS-1:0]    rsp1_result,
    output logic                rsp1_zero,

    output logic [CTRLBITS-1:0] alu_ctr,
    output logic [WORDS-1:0]    alu_a,
    output logic [WORDS-1:0]    alu_b,
    output logic [WORDS-1:0]    alu_pc,
    output logic [WORDS-1:0]    alu_imm,
    output logic                alu_srca,
    output logic                alu_srcb,
    input  logic [WORDS-1:0]    alu_result,
    input  logic                alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]         gnt_cnt0,
    output logic [15:0]         gnt_cnt1,
    output logic [15:0]         conflict_cnt
`endif
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e               last_q;
    port_e               iss_owner_q;
    logic                iss_valid_q;
    logic [CTRLBITS-1:0] iss_ctr_q;
    logic [WORDS-1:0]    iss_a_q;
    logic [WORDS-1:0]    iss_b_q;
    logic [WORDS-1:0]    iss_pc_q;
    logic [WORDS-1:0]    iss_imm_q;
    logic                iss_srca_q;
    logic                iss_srcb_q;

    logic                busy0, busy1;
    logic                elig0, elig1;
    logic                cand0, cand1;
    logic                acc0, acc1;
    logic                done0, done1;

    // Readiness is built from eligibility and the competing port only, never from the port's own valid.
    always_comb begin
        busy0      = iss_valid_q && (iss_owner_q == PORT0);
        busy1      = iss_valid_q && (iss_owner_q == PORT1);
        elig0      = !busy0 && (!rsp0_valid || rsp0_ready);
        elig1      = !busy1 && (!rsp1_valid || rsp1_ready);
        cand0      = req0_valid && elig0;
        cand1      = req1_valid && elig1;
        req0_ready = !rst && elig0 && (!cand1 || (last_q == PORT1));
        req1_ready = !rst && elig1 && (!cand0 || (last_q == PORT0));
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        done0      = busy0;
        done1      = busy1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_owner_q <= PORT0;
            iss_ctr_q   <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_pc_q    <= '0;
            iss_imm_q   <= '0;
            iss_srca_q  <= 1'b0;
            iss_srcb_q  <= 1'b0;
            last_q      <= PORT1;
        end else if (acc0) begin
            iss_valid_q <= 1'b1;
            iss_owner_q <= PORT0;
            iss_ctr_q   <= req0_ctr;
            iss_a_q     <= req0_a;
            iss_b_q     <= req0_b;
            iss_pc_q    <= req0_pc;
            iss_imm_q   <= req0_imm;
            iss_srca_q  <= req0_srca;
            iss_srcb_q  <= req0_srcb;
            last_q      <= PORT0;
        end else if (acc1) begin
            iss_valid_q <= 1'b1;
            iss_owner_q <= PORT1;
            iss_ctr_q   <= req1_ctr;
            iss_a_q     <= req1_a;
            iss_b_q     <= req1_b;
            iss_pc_q    <= req1_pc;
            iss_imm_q   <= req1_imm;
            iss_srca_q  <= req1_srca;
            iss_srcb_q  <= req1_srcb;
            last_q      <= PORT1;
        end else begin
            iss_valid_q <= 1'b0;
        end
    end

    // An empty issue stage presents the all-ones code so the ALU produces a harmless zero result.
    always_comb begin
        alu_ctr  = iss_valid_q ? iss_ctr_q : '1;
        alu_a    = iss_a_q;
        alu_b    = iss_b_q;
        alu_pc   = iss_pc_q;
        alu_imm  = iss_imm_q;
        alu_srca = iss_srca_q;
        alu_srcb = iss_srcb_q;
    end

    // Refill takes priority over a simultaneous pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
        end else if (done0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else if (done1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (acc0 && (gnt_cnt0 != 16'hFFFF))
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (acc1 && (gnt_cnt1 != 16'hFFFF))
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            if (cand0 && cand1 && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-cycle vector table plus hand sequences for
// operand-select routing, single-op latency and reset while an op is in flight.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] NOP = 4'hF;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req0_srca, req0_srcb;
    logic [3:0] req0_ctr;
    logic [W-1:0] req0_a, req0_b, req0_pc, req0_imm;
    logic req1_valid, req1_ready, req1_srca, req1_srcb;
    logic [3:0] req1_ctr;
    logic [W-1:0] req1_a, req1_b, req1_pc, req1_imm;
    logic rsp0_valid, rsp0_ready, rsp0_zero;
    logic [W-1:0] rsp0_result;
    logic rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0] rsp1_result;
    logic [3:0] alu_ctr;
    logic [W-1:0] alu_a, alu_b, alu_pc, alu_imm, alu_result;
    logic alu_srca, alu_srcb, alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WORDS(W), .CTRLBITS(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
        .req0_a(req0_a), .req0_b(req0_b), .req0_pc(req0_pc), .req0_imm(req0_imm),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
        .req1_a(req1_a), .req1_b(req1_b), .req1_pc(req1_pc), .req1_imm(req1_imm),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_imm(alu_imm),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Minimal external ALU: 0 = add, 1 = subtract, anything else yields zero.
    logic [W-1:0] opa, opb;
    always_comb begin
        opa = alu_srca ? alu_pc : alu_a;
        opb = alu_srcb ? alu_imm : alu_b;
        case (alu_ctr)
            ADD:     alu_result = opa + opb;
            SUB:     alu_result = opa - opb;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        bit v0; logic [3:0] c0; logic [W-1:0] a0, b0; bit rr0;
        bit v1; logic [3:0] c1; logic [W-1:0] a1, b1; bit rr1;
        bit er0, er1;
        bit erv0; logic [W-1:0] eres0; bit ez0;
        bit erv1; logic [W-1:0] eres1; bit ez1;
        logic [3:0] ectr; logic [W-1:0] ea;
    } vec_t;

    function automatic vec_t mk(
        input bit v0, input logic [3:0] c0, input logic [W-1:0] a0, input logic [W-1:0] b0, input bit rr0,
        input bit v1, input logic [3:0] c1, input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rr1,
        input bit er0, input bit er1,
        input bit erv0, input logic [W-1:0] eres0, input bit ez0,
        input bit erv1, input logic [W-1:0] eres1, input bit ez1,
        input logic [3:0] ectr, input logic [W-1:0] ea);
        vec_t t;
        t.v0 = v0; t.c0 = c0; t.a0 = a0; t.b0 = b0; t.rr0 = rr0;
        t.v1 = v1; t.c1 = c1; t.a1 = a1; t.b1 = b1; t.rr1 = rr1;
        t.er0 = er0; t.er1 = er1;
        t.erv0 = erv0; t.eres0 = eres0; t.ez0 = ez0;
        t.erv1 = erv1; t.eres1 = eres1; t.ez1 = ez1;
        t.ectr = ectr; t.ea = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set0(input bit v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = v; req0_ctr = c; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input bit v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = v; req1_ctr = c; req1_a = a; req1_b = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set0(1'b1, ADD, '0, '0); set1(1'b1, ADD, '0, '0);
        req0_pc = '0; req0_imm = '0; req0_srca = 1'b0; req0_srcb = 1'b0;
        req1_pc = '0; req1_imm = '0; req1_srca = 1'b0; req1_srcb = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        for (int i = 0; i < 2; i++) begin
            next_cycle();
            rst = 1'b1;
            #4;
            chk($sformatf("reset%0d ready0", i), 32'(req0_ready), 32'(0));
            chk($sformatf("reset%0d ready1", i), 32'(req1_ready), 32'(0));
            chk($sformatf("reset%0d rsp0_valid", i), 32'(rsp0_valid), 32'(0));
            chk($sformatf("reset%0d rsp1_valid", i), 32'(rsp1_valid), 32'(0));
            chk($sformatf("reset%0d alu_ctr", i), 32'(alu_ctr), 32'(NOP));
            chk($sformatf("reset%0d alu_a", i), alu_a, '0);
        end

        //             v0 c0   a0 b0 rr0 v1 c1   a1  b1 rr1 er0 er1 erv0 res0 z0 erv1 res1 z1 ctr  a
        tbl[0]  = mk(H, ADD, 1, 2, H, H, SUB, 10, 3, H, H, L, L, 0,  L, L, 0,  L, NOP, 0);
        tbl[1]  = mk(H, ADD, 3, 4, H, H, SUB, 10, 3, H, L, H, L, 0,  L, L, 0,  L, ADD, 1);
        tbl[2]  = mk(H, ADD, 3, 4, H, H, SUB, 20, 5, H, H, L, H, 3,  L, L, 0,  L, SUB, 10);
        tbl[3]  = mk(H, ADD, 5, 6, H, H, SUB, 20, 5, H, L, H, L, 0,  L, H, 7,  L, ADD, 3);
        tbl[4]  = mk(L, ADD, 0, 0, H, L, ADD, 0,  0, H, H, L, H, 7,  L, L, 0,  L, SUB, 20);
        tbl[5]  = mk(L, ADD, 0, 0, H, L, ADD, 0,  0, H, H, H, L, 0,  L, H, 15, L, NOP, 20);
        tbl[6]  = mk(H, ADD, 8, 8, L, H, SUB, 9,  1, H, H, L, L, 0,  L, L, 0,  L, NOP, 20);
        tbl[7]  = mk(H, ADD, 2, 2, L, H, SUB, 9,  1, H, L, H, L, 0,  L, L, 0,  L, ADD, 8);
        tbl[8]  = mk(H, ADD, 2, 2, L, H, SUB, 7,  2, H, L, L, H, 16, L, L, 0,  L, SUB, 9);
        tbl[9]  = mk(H, ADD, 2, 2, L, H, SUB, 7,  2, H, L, H, H, 16, L, H, 8,  L, NOP, 9);
        tbl[10] = mk(H, ADD, 2, 2, L, H, SUB, 4,  4, H, L, L, H, 16, L, L, 0,  L, SUB, 7);
        tbl[11] = mk(H, ADD, 2, 2, L, H, SUB, 4,  4, H, L, H, H, 16, L, H, 5,  L, NOP, 7);
        tbl[12] = mk(H, ADD, 2, 2, H, L, SUB, 4,  4, H, H, L, H, 16, L, L, 0,  L, SUB, 4);
        tbl[13] = mk(L, ADD, 0, 0, H, L, ADD, 0,  0, L, L, L, L, 0,  L, H, 0,  H, ADD, 2);
        tbl[14] = mk(L, ADD, 0, 0, L, H, SUB, 30, 10, H, L, H, H, 4, L, H, 0,  H, NOP, 2);
        tbl[15] = mk(L, ADD, 0, 0, L, L, ADD, 0,  0, H, L, L, H, 4,  L, L, 0,  L, SUB, 30);
        tbl[16] = mk(L, ADD, 0, 0, H, L, ADD, 0,  0, H, H, H, H, 4,  L, H, 20, L, NOP, 30);

        for (int i = 0; i < 17; i++) begin
            next_cycle();
            rst = 1'b0;
            set0(tbl[i].v0, tbl[i].c0, tbl[i].a0, tbl[i].b0);
            set1(tbl[i].v1, tbl[i].c1, tbl[i].a1, tbl[i].b1);
            rsp0_ready = tbl[i].rr0;
            rsp1_ready = tbl[i].rr1;
            #4;
            chk($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(tbl[i].er0));
            chk($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(tbl[i].er1));
            chk($sformatf("v%0d rsp0_valid", i), 32'(rsp0_valid), 32'(tbl[i].erv0));
            chk($sformatf("v%0d rsp1_valid", i), 32'(rsp1_valid), 32'(tbl[i].erv1));
            chk($sformatf("v%0d alu_ctr", i), 32'(alu_ctr), 32'(tbl[i].ectr));
            chk($sformatf("v%0d alu_a", i), alu_a, tbl[i].ea);
            if (tbl[i].erv0) begin
                chk($sformatf("v%0d rsp0_result", i), rsp0_result, tbl[i].eres0);
                chk($sformatf("v%0d rsp0_zero", i), 32'(rsp0_zero), 32'(tbl[i].ez0));
            end
            if (tbl[i].erv1) begin
                chk($sformatf("v%0d rsp1_result", i), rsp1_result, tbl[i].eres1);
                chk($sformatf("v%0d rsp1_zero", i), 32'(rsp1_zero), 32'(tbl[i].ez1));
            end
        end

        // PC/immediate operand selects routed through the issue stage on port 1.
        next_cycle();
        set0(1'b0, ADD, '0, '0);
        set1(1'b1, ADD, 32'hDEAD, 32'hDEAD);
        req1_pc = 32'h1000; req1_imm = 32'h20; req1_srca = 1'b1; req1_srcb = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #4;
        chk("sel accept ready1", 32'(req1_ready), 32'(1));
        next_cycle();
        set1(1'b0, ADD, '0, '0);
        req1_pc = '0; req1_imm = '0; req1_srca = 1'b0; req1_srcb = 1'b0;
        #4;
        chk("sel alu_ctr", 32'(alu_ctr), 32'(ADD));
        chk("sel alu_srca", 32'(alu_srca), 32'(1));
        chk("sel alu_srcb", 32'(alu_srcb), 32'(1));
        chk("sel alu_pc", alu_pc, 32'h1000);
        chk("sel alu_imm", alu_imm, 32'h20);
        next_cycle();
        #4;
        chk("sel rsp1_valid", 32'(rsp1_valid), 32'(1));
        chk("sel rsp1_result", rsp1_result, 32'h1020);
        chk("sel rsp1_zero", 32'(rsp1_zero), 32'(0));

        // Single ADD on port 0: operands at T+1, response at T+2.
        next_cycle();
        set0(1'b1, ADD, 5, 7);
        #4;
        chk("add ready0", 32'(req0_ready), 32'(1));
        chk("add rsp1 popped", 32'(rsp1_valid), 32'(0));
        next_cycle();
        set0(1'b0, ADD, '0, '0);
        #4;
        chk("add alu_a", alu_a, 5);
        chk("add alu_b", alu_b, 7);
        chk("add alu_ctr", 32'(alu_ctr), 32'(ADD));
        chk("add rsp0_valid early", 32'(rsp0_valid), 32'(0));
        next_cycle();
        #4;
        chk("add rsp0_valid", 32'(rsp0_valid), 32'(1));
        chk("add rsp0_result", rsp0_result, 12);
        chk("add rsp0_zero", 32'(rsp0_zero), 32'(0));

        // Reset while an op sits in the issue stage: it must never produce a response.
        next_cycle();
        set0(1'b1, ADD, 9, 9);
        #4;
        chk("rstmid ready0", 32'(req0_ready), 32'(1));
        next_cycle();
        rst = 1'b1;
        set0(1'b1, ADD, 1, 1); set1(1'b1, ADD, 1, 1);
        #4;
        chk("rstmid ready0 forced", 32'(req0_ready), 32'(0));
        chk("rstmid ready1 forced", 32'(req1_ready), 32'(0));
        chk("rstmid alu_ctr inflight", 32'(alu_ctr), 32'(ADD));
        chk("rstmid alu_a inflight", alu_a, 9);
        next_cycle();
        rst = 1'b0;
        set0(1'b0, ADD, '0, '0); set1(1'b0, ADD, '0, '0);
        #4;
        chk("rstmid alu_ctr", 32'(alu_ctr), 32'(NOP));
        chk("rstmid alu_a", alu_a, '0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstmid%0d rsp0_valid", i), 32'(rsp0_valid), 32'(0));
            chk($sformatf("rstmid%0d rsp1_valid", i), 32'(rsp1_valid), 32'(0));
            next_cycle();
            #4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
